// File: rtl/lane_register_file_if.sv
// rtl/lane_register_file_if.sv - issue/writeback bus for the per-lane vector register file
interface lane_register_file_if #(
    parameter int NUM_LANES  = 16,
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 64,
    parameter int NUM_RPORTS = 2
);
    logic                                   clear_req;
    logic                                   ready;
    logic [NUM_LANES-1:0]                   write_en;
    logic [ADDR_W-1:0]                      waddr;
    logic [NUM_LANES*DATA_W-1:0]            wdata;
    logic [NUM_RPORTS*NUM_LANES-1:0]        read_en;
    logic [NUM_RPORTS*ADDR_W-1:0]           raddr;
    logic [NUM_RPORTS*NUM_LANES*DATA_W-1:0] rdata;
    logic [NUM_RPORTS-1:0]                  rvalid;

    modport master (
        output clear_req, write_en, waddr, wdata, read_en, raddr,
        input  ready, rdata, rvalid
    );

    modport slave (
        input  clear_req, write_en, waddr, wdata, read_en, raddr,
        output ready, rdata, rvalid
    );
endinterface

// File: rtl/lane_register_file.sv
// rtl/lane_register_file.sv - per-lane SIMT register file with clear sequencer, registered reads
// Optional same-cycle write-to-read forwarding is built when LRF_BYPASS_EN is defined.
module lane_register_file #(
    parameter int NUM_LANES  = 16,
    parameter int NUM_REGS   = 16,
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 64,
    parameter int NUM_RPORTS = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    lane_register_file_if.slave bus
);
    typedef enum logic {S_INIT, S_READY} state_t;

    localparam logic [ADDR_W-1:0] LAST_REG  = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W:0]   REG_LIMIT = (ADDR_W + 1)'(NUM_REGS);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              ready;
    logic              sweep;
    logic              wr_ok;

    logic [DATA_W-1:0]                      mem_q [NUM_LANES][NUM_REGS];
    logic [NUM_RPORTS*NUM_LANES*DATA_W-1:0] rdata_q, rdata_d;
    logic [NUM_RPORTS-1:0]                  rvalid_q, rvalid_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_INIT;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // clear_req is only honoured in READY, so a running sweep is never restarted
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            S_INIT: begin
                if (clr_cnt_q == LAST_REG) begin
                    state_d   = S_READY;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                end
            end
            S_READY: begin
                if (bus.clear_req) begin
                    state_d   = S_INIT;
                    clr_cnt_d = '0;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_comb begin
        ready = (state_q == S_READY);
        sweep = (state_q == S_INIT);
    end

    assign wr_ok = ready && !bus.clear_req && ({1'b0, bus.waddr} < REG_LIMIT);

    always_ff @(posedge clk) begin
        for (int l = 0; l < NUM_LANES; l++) begin
            if (sweep) begin
                mem_q[l][clr_cnt_q] <= '0;
            end else if (wr_ok && bus.write_en[l]) begin
                mem_q[l][bus.waddr] <= bus.wdata[l*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        rvalid_d = '0;
        rdata_d  = '0;
        if (ready) begin
            for (int p = 0; p < NUM_RPORTS; p++) begin
                rvalid_d[p] = |bus.read_en[p*NUM_LANES +: NUM_LANES];
                if ({1'b0, bus.raddr[p*ADDR_W +: ADDR_W]} < REG_LIMIT) begin
                    for (int l = 0; l < NUM_LANES; l++) begin
                        if (bus.read_en[p*NUM_LANES + l]) begin
`ifdef LRF_BYPASS_EN
                            if (wr_ok && bus.write_en[l] &&
                                bus.waddr == bus.raddr[p*ADDR_W +: ADDR_W]) begin
                                rdata_d[(p*NUM_LANES + l)*DATA_W +: DATA_W] =
                                    bus.wdata[l*DATA_W +: DATA_W];
                            end else begin
                                rdata_d[(p*NUM_LANES + l)*DATA_W +: DATA_W] =
                                    mem_q[l][bus.raddr[p*ADDR_W +: ADDR_W]];
                            end
`else
                            rdata_d[(p*NUM_LANES + l)*DATA_W +: DATA_W] =
                                mem_q[l][bus.raddr[p*ADDR_W +: ADDR_W]];
`endif
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus.ready  = ready;
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = rdata_q;
endmodule
